// File: rtl/hazard_tracker.sv
// D-stage hazard tracker: tracks E/M/W producers with decrementing Tnew counters, drives stall/flush and forward selects.
// Zero output latency (all outputs combinational); stall freezes F/D and bubbles E while M/W keep draining.
module hazard_tracker #(
    parameter logic [3:0] T_NONE = 4'd15,
    parameter int          AW     = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rs_d,
    input  logic [AW-1:0] rt_d,
    input  logic [3:0]    tuse_rs_d,
    input  logic [3:0]    tuse_rt_d,
    input  logic [3:0]    tnew_d,
    input  logic          wr_d,
    input  logic [AW-1:0] a3_d,
    input  logic          ext_stall,
    output logic          stall,
    output logic          flush_e,
    output logic [1:0]    fwd_rs_d,
    output logic [1:0]    fwd_rt_d,
    output logic [1:0]    fwd_rs_e,
    output logic [1:0]    fwd_rt_e,
    output logic          fwd_rt_m
);

    logic [AW-1:0] a3_e, rs_e, rt_e, a3_m, rt_m, a3_w;
    logic [3:0]    tnew_e, tnew_m, tnew_w;
    logic          hazard_rs, hazard_rt;

    function automatic logic [3:0] dec(input logic [3:0] x);
        return (x == 4'd0 || x == T_NONE) ? 4'd0 : x - 4'd1;
    endfunction

    function automatic logic match(input logic [AW-1:0] a3, input logic [AW-1:0] r);
        return (r != '0) && (a3 == r);
    endfunction

    function automatic logic raw(input logic [AW-1:0] r, input logic [3:0] tuse,
                                 input logic [AW-1:0] a3e, input logic [3:0] te,
                                 input logic [AW-1:0] a3m, input logic [3:0] tm);
        return (tuse != T_NONE) &&
               ((match(a3e, r) && (te > tuse)) || (match(a3m, r) && (tm > tuse)));
    endfunction

    // Nearest matching stage wins; a match whose result is not ready yet selects nothing.
    function automatic logic [1:0] sel_d(input logic [AW-1:0] r,
                                         input logic [AW-1:0] a3e, input logic [3:0] te,
                                         input logic [AW-1:0] a3m, input logic [3:0] tm,
                                         input logic [AW-1:0] a3w, input logic [3:0] tw);
        logic [1:0] s;
        s = 2'd0;
        if (match(a3e, r))      s = (te == 4'd0) ? 2'd1 : 2'd0;
        else if (match(a3m, r)) s = (tm == 4'd0) ? 2'd2 : 2'd0;
        else if (match(a3w, r)) s = (tw == 4'd0) ? 2'd3 : 2'd0;
        return s;
    endfunction

    function automatic logic [1:0] sel_e(input logic [AW-1:0] r,
                                         input logic [AW-1:0] a3m, input logic [3:0] tm,
                                         input logic [AW-1:0] a3w, input logic [3:0] tw);
        logic [1:0] s;
        s = 2'd0;
        if (match(a3m, r))      s = (tm == 4'd0) ? 2'd2 : 2'd0;
        else if (match(a3w, r)) s = (tw == 4'd0) ? 2'd3 : 2'd0;
        return s;
    endfunction

    always_comb begin
        hazard_rs = raw(rs_d, tuse_rs_d, a3_e, tnew_e, a3_m, tnew_m);
        hazard_rt = raw(rt_d, tuse_rt_d, a3_e, tnew_e, a3_m, tnew_m);
        stall     = hazard_rs | hazard_rt | ext_stall;
        flush_e   = stall;
        fwd_rs_d  = sel_d(rs_d, a3_e, tnew_e, a3_m, tnew_m, a3_w, tnew_w);
        fwd_rt_d  = sel_d(rt_d, a3_e, tnew_e, a3_m, tnew_m, a3_w, tnew_w);
        fwd_rs_e  = sel_e(rs_e, a3_m, tnew_m, a3_w, tnew_w);
        fwd_rt_e  = sel_e(rt_e, a3_m, tnew_m, a3_w, tnew_w);
        fwd_rt_m  = match(a3_w, rt_m) && (tnew_w == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a3_e   <= '0;
            tnew_e <= '0;
            rs_e   <= '0;
            rt_e   <= '0;
            a3_m   <= '0;
            tnew_m <= '0;
            rt_m   <= '0;
            a3_w   <= '0;
            tnew_w <= '0;
        end else begin
            if (stall) begin
                a3_e   <= '0;
                tnew_e <= '0;
                rs_e   <= '0;
                rt_e   <= '0;
            end else begin
                a3_e   <= (wr_d && tnew_d != T_NONE) ? a3_d : '0;
                tnew_e <= dec(tnew_d);
                rs_e   <= rs_d;
                rt_e   <= rt_d;
            end
            // M and W drain regardless of stall.
            a3_m   <= a3_e;
            tnew_m <= dec(tnew_e);
            rt_m   <= rt_e;
            a3_w   <= a3_m;
            tnew_w <= dec(tnew_m);
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Scenario bench for hazard_tracker: expected output vectors queued at drive time, popped and compared before the next edge.
module tb_hazard_tracker;

    localparam logic [3:0] TN = 4'd15;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [3:0] tuse_rs;
        logic [3:0] tuse_rt;
        logic [3:0] tnew;
        logic       wr;
        logic [4:0] a3;
        logic       ext;
        logic       rst;
    } stim_t;

    typedef struct packed {
        logic       stall;
        logic       flush;
        logic [1:0] frs_d;
        logic [1:0] frt_d;
        logic [1:0] frs_e;
        logic [1:0] frt_e;
        logic       frt_m;
    } out_t;

    logic       clk;
    logic       reset;
    logic [4:0] rs_d, rt_d, a3_d;
    logic [3:0] tuse_rs_d, tuse_rt_d, tnew_d;
    logic       wr_d, ext_stall;
    logic       stall, flush_e, fwd_rt_m;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    out_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    hazard_tracker dut (
        .clk       (clk),
        .reset     (reset),
        .rs_d      (rs_d),
        .rt_d      (rt_d),
        .tuse_rs_d (tuse_rs_d),
        .tuse_rt_d (tuse_rt_d),
        .tnew_d    (tnew_d),
        .wr_d      (wr_d),
        .a3_d      (a3_d),
        .ext_stall (ext_stall),
        .stall     (stall),
        .flush_e   (flush_e),
        .fwd_rs_d  (fwd_rs_d),
        .fwd_rt_d  (fwd_rt_d),
        .fwd_rs_e  (fwd_rs_e),
        .fwd_rt_e  (fwd_rt_e),
        .fwd_rt_m  (fwd_rt_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [3:0] trs, input logic [3:0] trt,
                                 input logic [3:0] tn, input logic wr,
                                 input logic [4:0] a3, input logic ext, input logic rst);
        stim_t s;
        s = '{rs: rs, rt: rt, tuse_rs: trs, tuse_rt: trt, tnew: tn,
              wr: wr, a3: a3, ext: ext, rst: rst};
        return s;
    endfunction

    function automatic out_t ex(input logic st, input logic [1:0] frsd, input logic [1:0] frtd,
                                input logic [1:0] frse, input logic [1:0] frte, input logic frtm);
        out_t o;
        o = '{stall: st, flush: st, frs_d: frsd, frt_d: frtd,
              frs_e: frse, frt_e: frte, frt_m: frtm};
        return o;
    endfunction

    task automatic drive(input stim_t s, input out_t e);
        @(negedge clk);
        reset     = s.rst;
        rs_d      = s.rs;
        rt_d      = s.rt;
        tuse_rs_d = s.tuse_rs;
        tuse_rt_d = s.tuse_rt;
        tnew_d    = s.tnew;
        wr_d      = s.wr;
        a3_d      = s.a3;
        ext_stall = s.ext;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rs_d = '0; rt_d = '0; a3_d = '0;
        tuse_rs_d = TN; tuse_rt_d = TN; tnew_d = TN;
        wr_d = 1'b0; ext_stall = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        stim_t st[3];
        out_t  e[3];
        out_t  exp_o, got_o;
        do_reset();
        st[0] = mk(0, 0, TN, TN, 3, 1, 5, 0, 0); e[0] = ex(0, 0, 0, 0, 0, 0);
        st[1] = mk(5, 5, 0, 0, TN, 0, 0, 0, 1);  e[1] = ex(1, 0, 0, 0, 0, 0);
        st[2] = mk(5, 5, 0, 0, TN, 0, 0, 0, 0);  e[2] = ex(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(st[i], e[i]);
            #2;
            exp_o = sb.pop_front();
            got_o = {stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL reset step %0d: got %b expected %b", i, got_o, exp_o);
            end
        end
    endtask

    task automatic test_alu_branch();
        stim_t st[4];
        out_t  e[4];
        out_t  exp_o, got_o;
        do_reset();
        st[0] = mk(1, 2, 1, 1, 2, 1, 3, 0, 0);   e[0] = ex(0, 0, 0, 0, 0, 0);
        st[1] = mk(3, 0, 0, 0, TN, 0, 0, 0, 0);  e[1] = ex(1, 0, 0, 0, 0, 0);
        st[2] = mk(3, 0, 0, 0, TN, 0, 0, 0, 0);  e[2] = ex(0, 2, 0, 0, 0, 0);
        st[3] = mk(0, 0, TN, TN, TN, 0, 0, 0, 0); e[3] = ex(0, 0, 0, 3, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(st[i], e[i]);
            #2;
            exp_o = sb.pop_front();
            got_o = {stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL alu_branch step %0d: got %b expected %b", i, got_o, exp_o);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t st[4];
        out_t  e[4];
        out_t  exp_o, got_o;
        do_reset();
        st[0] = mk(5, 4, 1, TN, 3, 1, 4, 0, 0);  e[0] = ex(0, 0, 0, 0, 0, 0);
        st[1] = mk(4, 6, 1, 1, 2, 1, 7, 0, 0);   e[1] = ex(1, 0, 0, 0, 0, 0);
        st[2] = mk(4, 6, 1, 1, 2, 1, 7, 0, 0);   e[2] = ex(0, 0, 0, 0, 0, 0);
        st[3] = mk(0, 0, TN, TN, TN, 0, 0, 0, 0); e[3] = ex(0, 0, 0, 3, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(st[i], e[i]);
            #2;
            exp_o = sb.pop_front();
            got_o = {stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL load_use step %0d: got %b expected %b", i, got_o, exp_o);
            end
        end
    endtask

    task automatic test_store_data();
        stim_t st[4];
        out_t  e[4];
        out_t  exp_o, got_o;
        do_reset();
        st[0] = mk(5, 0, 1, TN, 3, 1, 4, 0, 0);  e[0] = ex(0, 0, 0, 0, 0, 0);
        st[1] = mk(5, 4, 1, 2, TN, 0, 0, 0, 0);  e[1] = ex(0, 0, 0, 0, 0, 0);
        st[2] = mk(0, 0, TN, TN, TN, 0, 0, 0, 0); e[2] = ex(0, 0, 0, 0, 0, 0);
        st[3] = mk(0, 0, TN, TN, TN, 0, 0, 0, 0); e[3] = ex(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(st[i], e[i]);
            #2;
            exp_o = sb.pop_front();
            got_o = {stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL store_data step %0d: got %b expected %b", i, got_o, exp_o);
            end
        end
    endtask

    task automatic test_jal_jr();
        stim_t st[2];
        out_t  e[2];
        out_t  exp_o, got_o;
        do_reset();
        st[0] = mk(0, 0, TN, TN, 0, 1, 31, 0, 0); e[0] = ex(0, 0, 0, 0, 0, 0);
        st[1] = mk(31, 0, 0, TN, TN, 0, 0, 0, 0); e[1] = ex(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            drive(st[i], e[i]);
            #2;
            exp_o = sb.pop_front();
            got_o = {stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL jal_jr step %0d: got %b expected %b", i, got_o, exp_o);
            end
        end
    endtask

    task automatic test_zero_reg();
        stim_t st[4];
        out_t  e[4];
        out_t  exp_o, got_o;
        do_reset();
        st[0] = mk(1, 2, 1, 1, 3, 1, 0, 0, 0);   e[0] = ex(0, 0, 0, 0, 0, 0);
        st[1] = mk(0, 0, 0, 0, TN, 0, 0, 0, 0);  e[1] = ex(0, 0, 0, 0, 0, 0);
        st[2] = mk(1, 2, 1, 1, 2, 0, 3, 0, 0);   e[2] = ex(0, 0, 0, 0, 0, 0);
        st[3] = mk(3, 3, 0, 0, TN, 0, 0, 0, 0);  e[3] = ex(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(st[i], e[i]);
            #2;
            exp_o = sb.pop_front();
            got_o = {stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL zero_reg step %0d: got %b expected %b", i, got_o, exp_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[5];
        out_t  e[5];
        out_t  exp_o, got_o;
        do_reset();
        st[0] = mk(0, 0, TN, TN, 1, 1, 2, 0, 0);  e[0] = ex(0, 0, 0, 0, 0, 0);
        st[1] = mk(0, 0, TN, TN, 1, 1, 2, 0, 0);  e[1] = ex(0, 0, 0, 0, 0, 0);
        st[2] = mk(2, 2, 1, 1, 2, 1, 9, 0, 0);    e[2] = ex(0, 1, 1, 0, 0, 0);
        st[3] = mk(0, 0, TN, TN, TN, 0, 0, 0, 0); e[3] = ex(0, 0, 0, 2, 2, 0);
        st[4] = mk(0, 0, TN, TN, TN, 0, 0, 0, 0); e[4] = ex(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            drive(st[i], e[i]);
            #2;
            exp_o = sb.pop_front();
            got_o = {stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL back_to_back step %0d: got %b expected %b", i, got_o, exp_o);
            end
        end
    endtask

    task automatic test_ext_stall();
        stim_t st[4];
        out_t  e[4];
        out_t  exp_o, got_o;
        do_reset();
        st[0] = mk(5, 0, 1, TN, 3, 1, 4, 0, 0);  e[0] = ex(0, 0, 0, 0, 0, 0);
        st[1] = mk(4, 6, 1, 1, 2, 1, 7, 1, 0);   e[1] = ex(1, 0, 0, 0, 0, 0);
        st[2] = mk(4, 6, 1, 1, 2, 1, 7, 1, 0);   e[2] = ex(1, 0, 0, 0, 0, 0);
        st[3] = mk(4, 6, 1, 1, 2, 1, 7, 0, 0);   e[3] = ex(0, 3, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(st[i], e[i]);
            #2;
            exp_o = sb.pop_front();
            got_o = {stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL ext_stall step %0d: got %b expected %b", i, got_o, exp_o);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t st[4];
        out_t  e[4];
        out_t  exp_o, got_o;
        do_reset();
        st[0] = mk(5, 0, 1, TN, 3, 1, 4, 0, 0);  e[0] = ex(0, 0, 0, 0, 0, 0);
        st[1] = mk(4, 6, 1, 1, 2, 1, 7, 0, 1);   e[1] = ex(1, 0, 0, 0, 0, 0);
        st[2] = mk(4, 6, 1, 1, 2, 1, 7, 0, 0);   e[2] = ex(0, 0, 0, 0, 0, 0);
        st[3] = mk(4, 6, 1, 1, 2, 1, 7, 1, 0);   e[3] = ex(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(st[i], e[i]);
            #2;
            exp_o = sb.pop_front();
            got_o = {stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL reset_mid_stall step %0d: got %b expected %b", i, got_o, exp_o);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rs_d = '0; rt_d = '0; a3_d = '0;
        tuse_rs_d = TN; tuse_rt_d = TN; tnew_d = TN;
        wr_d = 1'b0; ext_stall = 1'b0;
        test_reset();
        test_alu_branch();
        test_load_use();
        test_store_data();
        test_jal_jr();
        test_zero_reg();
        test_back_to_back();
        test_ext_stall();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Consumer side of the decoder's Tuse/Tnew interface in the 5-stage (F/D/E/M/W) pipeline.
- Takes the D-stage instruction's register addresses, Tuse codes, Tnew code and write destination.
- Tracks every in-flight producer in E/M/W with its own decrementing Tnew counter.
- Generates the D-stage stall/E-stage flush and all forwarding selects for D, E and M consumers.

Parameters:
- T_NONE, 15: 4-bit code meaning "operand never used" (Tuse) or "no result" (Tnew).
- AW, 5: register-address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rs_d  in  AW  D-stage rs address.
- rt_d  in  AW  D-stage rt address.
- tuse_rs_d  in  4  cycles from D until rs is consumed; T_NONE = unused.
- tuse_rt_d  in  4  same for rt.
- tnew_d  in  4  cycles from D until the result is forwardable; T_NONE = none.
- wr_d  in  1  D-stage instruction writes a GPR.
- a3_d  in  AW  D-stage destination register.
- ext_stall  in  1  external stall request (e.g. multiply/divide busy with a dependent op in D).
- stall  out  1  freeze PC and F/D register.
- flush_e  out  1  insert a bubble into E this cycle; always equal to stall.
- fwd_rs_d  out  2  D rs source: 0 RF, 1 E, 2 M, 3 W.
- fwd_rt_d  out  2  same encoding as fwd_rs_d.
- fwd_rs_e  out  2  E rs source: 0 pipe reg, 2 M, 3 W.
- fwd_rt_e  out  2  same encoding as fwd_rs_e.
- fwd_rt_m  out  1  M rt (store data) source: 0 pipe reg, 1 W.

Behaviour:
- State per stage S in {E, M, W}: a3_S (AW), tnew_S (4 bits), plus rs_E, rt_E, rt_M.
- Reset (synchronous, clk edge with reset=1): every field cleared to 0. With all fields 0, all outputs are 0 regardless of D inputs.
- Entry into E: a3_E <= (wr_d && tnew_d != T_NONE) ? a3_d : 0.
- Tnew on entry into E: tnew_E <= dec(tnew_d), where dec(x) = (x == 0 || x == T_NONE) ? 0 : x-1.
- rs_E/rt_E on entry into E: take rs_d/rt_d.
- Advance each cycle: M <= E with tnew dec'd, W <= M with tnew dec'd, rt_M <= rt_E. M and W always advance, even during a stall.
- Stall: E loads a bubble (all fields 0). The D inputs are held by the F/D register freeze, so the same instruction is re-evaluated next cycle.
- Match(S, r): r != 0 and a3_S == r.
- Raw hazard on rs: tuse_rs_d != T_NONE and (Match(E,rs_d) and tnew_E > tuse_rs_d, or Match(M,rs_d) and tnew_M > tuse_rs_d). Same rule for rt.
- stall = hazard_rs | hazard_rt | ext_stall; flush_e = stall. Both are combinational, same cycle.
- W is never a stall source: tnew_W is always 0 by construction.
- Forward priority is nearest stage first, E > M > W, and selection stops at the first matching stage.
- If the first matching stage has tnew != 0, the select is 0 (no forward). This is never consumed incorrectly because the stall covers it.
- fwd_rs_e/fwd_rt_e search M then W using rs_E/rt_E; fwd_rt_m checks W using rt_M.
- Register 0 never matches: never stalls, never forwards.
- Simultaneous stall and ext_stall: a single stall cycle per cycle, no double counting.
- Reset asserted mid-stall: the next cycle has all stages empty and stall=0 unless ext_stall=1.
- All outputs are combinational from the state registers and D inputs; there is no output latency.

Test Plan:
- Reset with rs_d=rt_d=5, tuse=0, ext_stall=0 -> stall=0, all fwd=0.
- ALU producer to beq: D: add $3 (wr=1, tnew=2), next D: beq rs=3 tuse=0.
  - Cycle 1 -> stall=1 (tnew_E=1>0).
  - Cycle 2 -> stall=0, fwd_rs_d=2 (M, tnew_M=0).
- Load-use: lw $4 (tnew=3), then add rs=4 tuse=1.
  - Cycle 1 -> stall=1 (tnew_E=2>1).
  - Cycle 2 -> stall=0; cycle 3 in E -> fwd_rs_e=3 (W).
- lw $4 then sw rt=4 tuse_rt=2 -> stall=0; two cycles later in M -> fwd_rt_m=1.
- jal (a3=31, tnew=0) then jr rs=31 tuse=0 -> stall=0, fwd_rs_d=1 (E).
- Destination $0 with tnew=3, consumer rs=0 tuse=0 -> stall=0, fwd=0.
- Priority: $2 written in both M and W, consumer in E -> fwd_rs_e=2.
